adau_spi_arbiter: RTL and testbench

Shares the single ADAU1761 control-port SPI master between two command sources: the boot-time `adau_command_list` sequencer and CPU-issued runtime commands pushed from the Wishbone register file. Runtime commands are buffered in a small FIFO. Before `adau_init_done`, only the init source is served. After it, the two sources alternate round-robin. The block sits between `adau_command_list`/`wishbone_bus_logic` and `adau_spi_master` in the `clk_soc` domain.

---
 rtl/adau_spi_arb_pkg.sv | 15 +
 rtl/adau_cmd_fifo.sv | 60 ++++++
 rtl/adau_spi_arbiter.sv | 109 ++++++++++
 tb/tb_adau_spi_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adau_spi_arb_pkg.sv
// Shared types and constants for the ADAU1761 control-port SPI arbiter.
package adau_spi_arb_pkg;

    localparam int ADAU_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    localparam logic GRANT_INIT = 1'b0;
    localparam logic GRANT_CPU  = 1'b1;

endpackage

// File: rtl/adau_cmd_fifo.sv
// Small synchronous command FIFO with registered full/empty/level flags.
module adau_cmd_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           level_next;
    logic                  push_ok;
    logic                  pop_ok;

    // Full is the registered flag, so a push at full is dropped even if a pop lands in the same cycle.
    assign push_ok = wr_en && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        level_next = level;
        case ({push_ok, pop_ok})
            2'b10:   level_next = level + (AW+1)'(1);
            2'b01:   level_next = level - (AW+1)'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_next;
            full  <= (level_next == (AW+1)'(DEPTH));
            empty <= (level_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/adau_spi_arbiter.sv
// Arbitrates the ADAU1761 SPI master between the boot sequencer and buffered CPU commands.
module adau_spi_arbiter
    import adau_spi_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = ADAU_DATA_WIDTH,
    parameter int CPU_FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             init_command,
    input  logic                              init_valid,
    output logic                              init_ready,
    input  logic                              init_done,
    input  logic [DATA_WIDTH-1:0]             cpu_command,
    input  logic                              cpu_write,
    output logic                              cpu_full,
    output logic [$clog2(CPU_FIFO_DEPTH):0]   cpu_level,
    output logic                              cpu_overflow,
    input  logic                              cpu_overflow_clr,
    output logic [DATA_WIDTH-1:0]             spi_data,
    output logic                              spi_valid,
    input  logic                              spi_ready,
    output logic                              busy,
    output logic                              grant
);

    arb_state_t            state;
    logic                  last_grant;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  cpu_eligible;
    logic                  init_fire;
    logic                  cpu_pop;

    adau_cmd_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (CPU_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (cpu_write),
        .wr_data (cpu_command),
        .pop     (cpu_pop),
        .head    (fifo_head),
        .full    (cpu_full),
        .empty   (fifo_empty),
        .level   (cpu_level)
    );

    // init_ready never looks at init_valid, which keeps the handshake free of combinational loops.
    assign cpu_eligible = init_done && !fifo_empty;
    assign init_ready   = (state == ST_IDLE) && !reset &&
                          (!cpu_eligible || last_grant == GRANT_CPU);
    assign init_fire    = init_valid && init_ready;
    assign cpu_pop      = (state == ST_IDLE) && !init_fire && cpu_eligible;
    assign busy         = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            spi_valid  <= 1'b0;
            spi_data   <= '0;
            grant      <= GRANT_INIT;
            last_grant <= GRANT_CPU;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (init_fire) begin
                        spi_data   <= init_command;
                        spi_valid  <= 1'b1;
                        grant      <= GRANT_INIT;
                        last_grant <= GRANT_INIT;
                        state      <= ST_ISSUE;
                    end else if (cpu_pop) begin
                        spi_data   <= fifo_head;
                        spi_valid  <= 1'b1;
                        grant      <= GRANT_CPU;
                        last_grant <= GRANT_CPU;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (spi_ready) begin
                        spi_valid <= 1'b0;
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    spi_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_overflow <= 1'b0;
        end else if (cpu_write && cpu_full) begin
            cpu_overflow <= 1'b1;
        end else if (cpu_overflow_clr) begin
            cpu_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adau_spi_arbiter.sv
// Scoreboard bench for adau_spi_arbiter: expected SPI words are queued by a transaction-level model.
module tb_adau_spi_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef logic [DW-1:0] word_t;
    typedef word_t wq_t[$];
    typedef struct {
        word_t data;
        logic  grant;
    } exp_t;

    logic        clk;
    logic        reset;
    word_t       init_command;
    logic        init_valid;
    logic        init_ready;
    logic        init_done;
    word_t       cpu_command;
    logic        cpu_write;
    logic        cpu_full;
    logic [2:0]  cpu_level;
    logic        cpu_overflow;
    logic        cpu_overflow_clr;
    word_t       spi_data;
    logic        spi_valid;
    logic        spi_ready;
    logic        busy;
    logic        grant;

    int    vectors     = 0;
    int    miscompares = 0;
    exp_t  exp_q[$];
    word_t init_src_q[$];
    bit    init_en;
    int    ready_pct;
    wq_t   iw;
    wq_t   cw;
    word_t ow[5];

    adau_spi_arbiter #(
        .DATA_WIDTH     (DW),
        .CPU_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .init_command     (init_command),
        .init_valid       (init_valid),
        .init_ready       (init_ready),
        .init_done        (init_done),
        .cpu_command      (cpu_command),
        .cpu_write        (cpu_write),
        .cpu_full         (cpu_full),
        .cpu_level        (cpu_level),
        .cpu_overflow     (cpu_overflow),
        .cpu_overflow_clr (cpu_overflow_clr),
        .spi_data         (spi_data),
        .spi_valid        (spi_valid),
        .spi_ready        (spi_ready),
        .busy             (busy),
        .grant            (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input word_t act, input word_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference order: init wins first after reset, then the sources alternate while both have work.
    task automatic model_rr(input wq_t iq, input wq_t cq);
        bit cpu_turn = 1'b0;
        while (iq.size() != 0 || cq.size() != 0) begin
            if ((cpu_turn && cq.size() != 0) || iq.size() == 0) begin
                exp_q.push_back('{data: cq.pop_front(), grant: 1'b1});
                cpu_turn = 1'b0;
            end else begin
                exp_q.push_back('{data: iq.pop_front(), grant: 1'b0});
                cpu_turn = 1'b1;
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (spi_valid && spi_ready && !reset) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_spi_cmd: got 0x%0h, expected no command", spi_data);
                end else begin
                    e = exp_q.pop_front();
                    check("spi_data", spi_data, e.data);
                    check("spi_grant", word_t'(grant), word_t'(e.grant));
                end
            end
        end
    endtask

    task automatic tick(input bit push = 1'b0, input word_t w = '0, input bit clr = 1'b0);
        bit fire;
        @(negedge clk);
        cpu_write        = push;
        cpu_command      = w;
        cpu_overflow_clr = clr;
        spi_ready        = ($urandom_range(99) < ready_pct);
        init_valid       = init_en && (init_src_q.size() != 0);
        init_command     = init_valid ? init_src_q[0] : word_t'($urandom);
        #1;
        fire = init_valid && init_ready;
        @(posedge clk);
        if (fire) void'(init_src_q.pop_front());
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d commands outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    task automatic do_reset();
        init_en          = 1'b0;
        init_done        = 1'b0;
        init_valid       = 1'b0;
        cpu_write        = 1'b0;
        cpu_overflow_clr = 1'b0;
        spi_ready        = 1'b0;
        init_src_q.delete();
        #2 reset = 1'b1;
        #1;
        check("rst_spi_valid", word_t'(spi_valid), 0);
        check("rst_spi_data", spi_data, 0);
        check("rst_init_ready", word_t'(init_ready), 0);
        check("rst_grant", word_t'(grant), 0);
        check("rst_cpu_full", word_t'(cpu_full), 0);
        check("rst_cpu_level", word_t'(cpu_level), 0);
        check("rst_cpu_overflow", word_t'(cpu_overflow), 0);
        check("rst_busy", word_t'(busy), 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b0;
        init_command     = '0;
        init_valid       = 1'b0;
        init_done        = 1'b0;
        cpu_command      = '0;
        cpu_write        = 1'b0;
        cpu_overflow_clr = 1'b0;
        spi_ready        = 1'b0;
        init_en          = 1'b0;
        ready_pct        = 100;
        fork
            monitor();
        join_none

        // Init-only boot: CPU word stays queued until init_done
        do_reset();
        ready_pct = 60;
        tick(1'b1, 32'hCAFE0001);
        init_src_q.push_back(32'h00400000);
        init_src_q.push_back(32'h00401501);
        exp_q.push_back('{data: 32'h00400000, grant: 1'b0});
        exp_q.push_back('{data: 32'h00401501, grant: 1'b0});
        init_en = 1'b1;
        drain(200);
        repeat (5) tick();
        check("boot_cpu_level_held", word_t'(cpu_level), 1);
        check("boot_busy_queued", word_t'(busy), 1);
        check("boot_no_cpu_issue", word_t'(spi_valid), 0);
        exp_q.push_back('{data: 32'hCAFE0001, grant: 1'b1});
        init_done = 1'b1;
        drain(200);
        check("boot_level_empty", word_t'(cpu_level), 0);
        check("boot_busy_idle", word_t'(busy), 0);

        // Overflow and push-at-full with simultaneous pop
        do_reset();
        ready_pct = 100;
        for (int i = 0; i < 5; i++) ow[i] = word_t'($urandom);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, ow[i]);
            if (i == 2) begin
                check("ovf_level_3", word_t'(cpu_level), 3);
                check("ovf_not_full_3", word_t'(cpu_full), 0);
            end
            if (i == 3) check("ovf_full_after_4", word_t'(cpu_full), 1);
        end
        check("ovf_flag_set", word_t'(cpu_overflow), 1);
        check("ovf_level_4", word_t'(cpu_level), 4);
        tick(1'b1, word_t'($urandom), 1'b1);
        check("ovf_set_beats_clr", word_t'(cpu_overflow), 1);
        tick(1'b0, '0, 1'b1);
        check("ovf_clr", word_t'(cpu_overflow), 0);
        for (int i = 0; i < 4; i++) exp_q.push_back('{data: ow[i], grant: 1'b1});
        init_done = 1'b1;
        tick(1'b1, word_t'($urandom));
        check("ovf_pop_push_full_level", word_t'(cpu_level), 3);
        check("ovf_pop_push_full_flag", word_t'(cpu_overflow), 1);
        drain(200);
        check("ovf_drained_level", word_t'(cpu_level), 0);

        // Handshake hold and single GAP cycle
        do_reset();
        ready_pct = 0;
        ow[0] = word_t'($urandom);
        ow[1] = word_t'($urandom);
        init_src_q.push_back(ow[0]);
        init_src_q.push_back(ow[1]);
        exp_q.push_back('{data: ow[0], grant: 1'b0});
        exp_q.push_back('{data: ow[1], grant: 1'b0});
        init_en = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("hold_spi_valid", word_t'(spi_valid), 1);
            check("hold_spi_data", spi_data, ow[0]);
            check("hold_init_ready", word_t'(init_ready), 0);
            check("hold_no_second_accept", word_t'(init_src_q.size()), 1);
            tick();
        end
        ready_pct = 100;
        tick();
        check("gap_valid_low", word_t'(spi_valid), 0);
        tick();
        check("idle_valid_low", word_t'(spi_valid), 0);
        tick();
        check("next_issue_valid", word_t'(spi_valid), 1);
        check("next_issue_data", spi_data, ow[1]);
        drain(100);

        // Reset mid-ISSUE, then init wins the first grant
        do_reset();
        ready_pct = 0;
        tick(1'b1, word_t'($urandom));
        init_src_q.push_back(word_t'($urandom));
        init_en = 1'b1;
        tick();
        tick();
        check("midissue_valid", word_t'(spi_valid), 1);
        check("midissue_level", word_t'(cpu_level), 1);
        do_reset();
        ow[0] = word_t'($urandom);
        ow[1] = word_t'($urandom);
        tick(1'b1, ow[1]);
        check("post_rst_level", word_t'(cpu_level), 1);
        iw.delete(); cw.delete();
        iw.push_back(ow[0]);
        cw.push_back(ow[1]);
        model_rr(iw, cw);
        init_src_q = iw;
        ready_pct  = 100;
        init_done  = 1'b1;
        init_en    = 1'b1;
        drain(100);

        // Randomized round-robin rounds
        for (int r = 0; r < 6; r++) begin
            int k;
            int n;
            do_reset();
            ready_pct = $urandom_range(100, 30);
            k = $urandom_range(4, 1);
            n = k + $urandom_range(3, 1);
            iw.delete(); cw.delete();
            for (int i = 0; i < k; i++) begin
                cw.push_back(word_t'($urandom));
                tick(1'b1, cw[i]);
            end
            check("rr_fill_level", word_t'(cpu_level), word_t'(k));
            for (int i = 0; i < n; i++) iw.push_back(word_t'($urandom));
            model_rr(iw, cw);
            init_src_q = iw;
            init_done  = 1'b1;
            init_en    = 1'b1;
            drain(400);
            check("rr_level_empty", word_t'(cpu_level), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
